// File: rtl/sa_ram_rws_param_if.sv
// Port bundle for sa_ram_rws_param: read/write request side driven by the master,
// read data and init status returned by the RAM (slave).
interface sa_ram_rws_param_if #(
    parameter int AW     = 4,
    parameter int WIDTH  = 128,
    parameter int MASK_W = 16
);
    logic [AW-1:0]     ra;
    logic              re;
    logic [AW-1:0]     wa;
    logic              we;
    logic [MASK_W-1:0] wmask;
    logic [WIDTH-1:0]  di;
    logic [31:0]       pwrbus_ram_pd;
    logic [WIDTH-1:0]  dout;
    logic              dout_vld;
    logic              init_busy;

    modport master (
        output ra, re, wa, we, wmask, di, pwrbus_ram_pd,
        input  dout, dout_vld, init_busy
    );

    modport slave (
        input  ra, re, wa, we, wmask, di, pwrbus_ram_pd,
        output dout, dout_vld, init_busy
    );
endinterface

// File: rtl/sa_ram_rws_param.sv
// Lane-masked 1R1W RAM with a zero-fill sweep after reset; read latency 1 (OUT_REG=0) or 2 (OUT_REG=1),
// one read per cycle, no backpressure: requests are ignored while init_busy is high.
module sa_ram_rws_param #(
    parameter int DEPTH   = 16,
    parameter int WIDTH   = 128,
    parameter int AW      = 4,
    parameter int MASK_W  = 16,
    parameter bit BYPASS  = 1'b1,
    parameter bit OUT_REG = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    sa_ram_rws_param_if.slave  bus
);
    localparam int              LW      = WIDTH / MASK_W;
    localparam logic [AW:0]     DEPTH_A = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   LAST    = AW'(DEPTH - 1);

    typedef enum logic {INIT, READY} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     cnt, cnt_nxt;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic              wa_ok, ra_ok, wr_act, rd_fire;
    logic [WIDTH-1:0]  rd_data;
    logic [WIDTH-1:0]  rdat;
    logic              rvld;
    logic              unused_pwr;

    assign unused_pwr = ^bus.pwrbus_ram_pd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            INIT: begin
                if (cnt == LAST) begin
                    state_nxt = READY;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + AW'(1);
                end
            end
            READY:   state_nxt = READY;
            default: state_nxt = INIT;
        endcase
    end

    assign bus.init_busy = (state == INIT);
    assign wa_ok   = {1'b0, bus.wa} < DEPTH_A;
    assign ra_ok   = {1'b0, bus.ra} < DEPTH_A;
    assign wr_act  = (state == READY) && bus.we && wa_ok;
    assign rd_fire = (state == READY) && bus.re;

    // Out-of-range writes are dropped by wa_ok; a zero mask simply writes no lanes.
    always_ff @(posedge clk) begin
        if (state == INIT && !rst) begin
            mem[cnt] <= '0;
        end else if (wr_act) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (bus.wmask[i]) mem[bus.wa][i*LW +: LW] <= bus.di[i*LW +: LW];
            end
        end
    end

    // Same-address collision: forward the lanes being written when BYPASS is set.
    always_comb begin
        rd_data = ra_ok ? mem[bus.ra] : '0;
        if (BYPASS && wr_act && (bus.ra == bus.wa)) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (bus.wmask[i]) rd_data[i*LW +: LW] = bus.di[i*LW +: LW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdat <= '0;
            rvld <= 1'b0;
        end else begin
            rvld <= rd_fire;
            if (rd_fire) rdat <= rd_data;
        end
    end

    generate
        if (OUT_REG) begin : g_oreg
            logic [WIDTH-1:0] q_dat;
            logic             q_vld;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_dat <= '0;
                    q_vld <= 1'b0;
                end else begin
                    q_vld <= rvld;
                    if (rvld) q_dat <= rdat;
                end
            end

            assign bus.dout     = q_dat;
            assign bus.dout_vld = q_vld;
        end else begin : g_noreg
            assign bus.dout     = rdat;
            assign bus.dout_vld = rvld;
        end
    endgenerate
endmodule

// File: tb/tb_sa_ram_rws_param.sv
// Bench for sa_ram_rws_param: three configurations share one stimulus stream and are checked
// against a word-array reference model (u0 default, u1 BYPASS=0, u2 DEPTH=12/64b/8 lanes/OUT_REG=1).
`timescale 1ns/1ps
module tb_sa_ram_rws_param;
    localparam int NI = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   ra = '0, wa = '0;
    logic         re = 1'b0, we = 1'b0;
    logic [15:0]  wmask = '0;
    logic [127:0] di = '0;
    logic [31:0]  pwr = 32'hA5A5_0001;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sa_ram_rws_param_if #(.AW(4), .WIDTH(128), .MASK_W(16)) if0 ();
    sa_ram_rws_param_if #(.AW(4), .WIDTH(128), .MASK_W(16)) if1 ();
    sa_ram_rws_param_if #(.AW(4), .WIDTH(64),  .MASK_W(8))  if2 ();

    assign if0.ra = ra; assign if0.re = re; assign if0.wa = wa; assign if0.we = we;
    assign if0.wmask = wmask; assign if0.di = di; assign if0.pwrbus_ram_pd = pwr;
    assign if1.ra = ra; assign if1.re = re; assign if1.wa = wa; assign if1.we = we;
    assign if1.wmask = wmask; assign if1.di = di; assign if1.pwrbus_ram_pd = pwr;
    assign if2.ra = ra; assign if2.re = re; assign if2.wa = wa; assign if2.we = we;
    assign if2.wmask = wmask[7:0]; assign if2.di = di[63:0]; assign if2.pwrbus_ram_pd = pwr;

    sa_ram_rws_param #(.DEPTH(16), .WIDTH(128), .AW(4), .MASK_W(16), .BYPASS(1), .OUT_REG(0))
        u0 (.clk(clk), .rst(rst), .bus(if0));
    sa_ram_rws_param #(.DEPTH(16), .WIDTH(128), .AW(4), .MASK_W(16), .BYPASS(0), .OUT_REG(0))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    sa_ram_rws_param #(.DEPTH(12), .WIDTH(64), .AW(4), .MASK_W(8), .BYPASS(1), .OUT_REG(1))
        u2 (.clk(clk), .rst(rst), .bus(if2));

    function automatic int dep(int k);   return (k == 2) ? 12 : 16;  endfunction
    function automatic int wid(int k);   return (k == 2) ? 64 : 128; endfunction
    function automatic int lanes(int k); return (k == 2) ? 8 : 16;   endfunction
    function automatic bit byp(int k);   return (k != 1);            endfunction
    function automatic bit oreg(int k);  return (k == 2);            endfunction

    // Reference model: plain word arrays, a sweep countdown and a list of pending read results.
    logic [127:0] mm [NI][16];
    int           init_left [NI];
    logic [127:0] e_dout [NI];
    logic         e_vld [NI];
    logic [127:0] st_dat [NI];
    logic         st_vld [NI];

    function automatic logic [127:0] merge(int k, logic [127:0] old, logic [127:0] d, logic [15:0] m);
        logic [127:0] r;
        int lw;
        r  = old;
        lw = wid(k) / lanes(k);
        for (int b = 0; b < wid(k); b++) if (m[b / lw]) r[b] = d[b];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            init_left[k] = dep(k);
            e_dout[k] = '0; e_vld[k] = 1'b0;
            st_dat[k] = '0; st_vld[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < NI; k++) begin
                logic         rd;
                logic [127:0] data;
                rd = 1'b0; data = '0;
                if (init_left[k] > 0) begin
                    mm[k][dep(k) - init_left[k]] = '0;
                    init_left[k]--;
                end else begin
                    if (re) begin
                        rd = 1'b1;
                        if (int'(ra) < dep(k)) begin
                            data = mm[k][ra];
                            if (byp(k) && we && ra == wa) data = merge(k, data, di, wmask);
                        end
                    end
                    if (we && int'(wa) < dep(k)) mm[k][wa] = merge(k, mm[k][wa], di, wmask);
                end
                if (oreg(k)) begin
                    if (st_vld[k]) e_dout[k] = st_dat[k];
                    e_vld[k]  = st_vld[k];
                    st_vld[k] = rd;
                    if (rd) st_dat[k] = data;
                end else begin
                    e_vld[k] = rd;
                    if (rd) e_dout[k] = data;
                end
            end
        end
    endtask

    function automatic logic [127:0] obs_dout(int k);
        if (k == 0) return if0.dout;
        if (k == 1) return if1.dout;
        return {64'h0, if2.dout};
    endfunction
    function automatic logic obs_vld(int k);
        if (k == 0) return if0.dout_vld;
        if (k == 1) return if1.dout_vld;
        return if2.dout_vld;
    endfunction
    function automatic logic obs_busy(int k);
        if (k == 0) return if0.init_busy;
        if (k == 1) return if1.init_busy;
        return if2.init_busy;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; re = 1'b0; we = 1'b0;
        model_reset();
        tick(); tick();
        for (int k = 0; k < NI; k++) begin
            n_chk++;
            if (obs_dout(k) !== 128'h0 || obs_vld(k) !== 1'b0 || obs_busy(k) !== 1'b1) begin
                n_err++;
                $display("FAIL reset k=%0d dout=%h vld=%b busy=%b expected dout=0 vld=0 busy=1",
                         k, obs_dout(k), obs_vld(k), obs_busy(k));
            end
        end
    endtask

    task automatic test_init_sweep();
        int done [NI];
        for (int k = 0; k < NI; k++) done[k] = -1;
        rst = 1'b0;
        for (int t = 1; t <= 30; t++) begin
            re = (t <= 10); we = (t <= 10);
            ra = 4'($urandom); wa = 4'($urandom);
            di = {$urandom, $urandom, $urandom, $urandom}; wmask = 16'($urandom);
            tick();
            for (int k = 0; k < NI; k++) begin
                if (done[k] < 0 && obs_busy(k) === 1'b0) done[k] = t;
                n_chk++;
                if (obs_vld(k) !== e_vld[k] || obs_dout(k) !== e_dout[k] || obs_busy(k) !== (init_left[k] > 0)) begin
                    n_err++;
                    $display("FAIL init k=%0d t=%0d vld=%b busy=%b dout=%h expected vld=%b busy=%b dout=%h",
                             k, t, obs_vld(k), obs_busy(k), obs_dout(k), e_vld[k], init_left[k] > 0, e_dout[k]);
                end
            end
        end
        re = 1'b0; we = 1'b0;
        for (int k = 0; k < NI; k++) begin
            n_chk++;
            if (done[k] !== dep(k)) begin
                n_err++;
                $display("FAIL init_len k=%0d busy_cycles=%0d expected %0d", k, done[k], dep(k));
            end
        end
    endtask

    task automatic test_read_zero();
        int pulses [NI];
        for (int k = 0; k < NI; k++) pulses[k] = 0;
        for (int t = 0; t < 18; t++) begin
            re = (t < 16); we = 1'b0; ra = 4'(t);
            tick();
            for (int k = 0; k < NI; k++) begin
                if (obs_vld(k) === 1'b1 && obs_dout(k) === 128'h0) pulses[k]++;
                n_chk++;
                if (obs_vld(k) !== e_vld[k] || obs_dout(k) !== e_dout[k]) begin
                    n_err++;
                    $display("FAIL rd_zero k=%0d t=%0d vld=%b dout=%h expected vld=%b dout=%h",
                             k, t, obs_vld(k), obs_dout(k), e_vld[k], e_dout[k]);
                end
            end
        end
        for (int k = 0; k < NI; k++) begin
            n_chk++;
            if (pulses[k] !== 16) begin
                n_err++;
                $display("FAIL rd_zero_pulses k=%0d zero_pulses=%0d expected 16", k, pulses[k]);
            end
        end
    endtask

    task automatic test_mask_write();
        re = 1'b0; we = 1'b1; wa = 4'd3; di = '1; wmask = 16'h00FF;
        tick();
        we = 1'b0; re = 1'b1; ra = 4'd3;
        tick();
        re = 1'b0;
        n_chk++;
        if (if0.dout !== 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF || if0.dout_vld !== 1'b1) begin
            n_err++;
            $display("FAIL mask_wr u0 dout=%h vld=%b expected lower 64 ones vld=1", if0.dout, if0.dout_vld);
        end
        tick();
        n_chk++;
        if (if2.dout !== 64'hFFFF_FFFF_FFFF_FFFF || if2.dout_vld !== 1'b1 || if0.dout_vld !== 1'b0) begin
            n_err++;
            $display("FAIL mask_wr u2 dout=%h vld=%b u0vld=%b expected all ones vld=1 u0vld=0",
                     if2.dout, if2.dout_vld, if0.dout_vld);
        end
    endtask

    task automatic test_bypass();
        logic [127:0] rv;
        re = 1'b1; we = 1'b1; ra = 4'd5; wa = 4'd5; di = '1; wmask = 16'hFFFF;
        tick();
        n_chk++;
        if (if0.dout !== {128{1'b1}} || if1.dout !== 128'h0 || if0.dout_vld !== 1'b1 || if1.dout_vld !== 1'b1) begin
            n_err++;
            $display("FAIL bypass u0=%h u1=%h expected u0 all ones u1 zero", if0.dout, if1.dout);
        end
        we = 1'b0; ra = 4'd5;
        tick();
        n_chk++;
        if (if1.dout !== {128{1'b1}} || if2.dout !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_err++;
            $display("FAIL bypass_next u1=%h u2=%h expected all ones", if1.dout, if2.dout);
        end
        we = 1'b1; ra = 4'd6; wa = 4'd6; di = '1; wmask = 16'h0000;
        tick();
        n_chk++;
        if (if0.dout !== 128'h0 || if1.dout !== 128'h0) begin
            n_err++;
            $display("FAIL zero_mask u0=%h u1=%h expected 0", if0.dout, if1.dout);
        end
        rv = {$urandom, $urandom, $urandom, $urandom};
        ra = 4'd5; wa = 4'd13; di = rv; wmask = 16'hFFFF;
        tick();
        ra = 4'd13; we = 1'b0;
        tick();
        re = 1'b0;
        n_chk++;
        if (if0.dout !== rv || if1.dout !== rv) begin
            n_err++;
            $display("FAIL indep u0=%h u1=%h expected %h", if0.dout, if1.dout, rv);
        end
        tick();
        n_chk++;
        if (if2.dout !== 64'h0 || if2.dout_vld !== 1'b1) begin
            n_err++;
            $display("FAIL out_of_range u2 dout=%h vld=%b expected 0 vld=1", if2.dout, if2.dout_vld);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] v [4];
        for (int i = 0; i < 4; i++) begin
            v[i] = {$urandom, $urandom};
            re = 1'b0; we = 1'b1; wa = 4'(i); di = {64'h0, v[i]}; wmask = 16'hFFFF;
            tick();
        end
        we = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            logic ev;
            re = (t <= 4); ra = 4'(t - 1);
            tick();
            ev = (t >= 2 && t <= 5);
            n_chk++;
            if (if2.dout_vld !== ev) begin
                n_err++;
                $display("FAIL b2b_vld t=%0d vld=%b expected %b", t, if2.dout_vld, ev);
            end else if (ev && if2.dout !== v[t-2]) begin
                n_err++;
                $display("FAIL b2b_data t=%0d dout=%h expected %h", t, if2.dout, v[t-2]);
            end
        end
        re = 1'b0;
    endtask

    task automatic test_hold();
        logic [127:0] a, b;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = ~a;
        re = 1'b0; we = 1'b1; wa = 4'd7; di = a; wmask = 16'hFFFF;
        tick();
        we = 1'b0; re = 1'b1; ra = 4'd7;
        tick();
        re = 1'b0; we = 1'b1; wa = 4'd7; di = b;
        n_chk++;
        if (if0.dout !== a || if0.dout_vld !== 1'b1) begin
            n_err++;
            $display("FAIL hold_cap dout=%h vld=%b expected %h vld=1", if0.dout, if0.dout_vld, a);
        end
        tick();
        we = 1'b0;
        tick(); tick();
        n_chk++;
        if (if0.dout !== a || if0.dout_vld !== 1'b0) begin
            n_err++;
            $display("FAIL hold dout=%h vld=%b expected %h vld=0", if0.dout, if0.dout_vld, a);
        end
        re = 1'b1;
        tick();
        re = 1'b0;
        n_chk++;
        if (if0.dout !== b || if0.dout_vld !== 1'b1) begin
            n_err++;
            $display("FAIL hold_new dout=%h vld=%b expected %h", if0.dout, if0.dout_vld, b);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            re = ($urandom_range(0, 99) < 60);
            we = ($urandom_range(0, 99) < 60);
            ra = 4'($urandom);
            wa = ($urandom_range(0, 99) < 30) ? ra : 4'($urandom);
            case ($urandom_range(0, 3))
                0:       wmask = 16'h0000;
                1:       wmask = 16'hFFFF;
                default: wmask = 16'($urandom);
            endcase
            di = {$urandom, $urandom, $urandom, $urandom};
            tick();
            for (int k = 0; k < NI; k++) begin
                n_chk++;
                if (obs_vld(k) !== e_vld[k] || obs_dout(k) !== e_dout[k] || obs_busy(k) !== 1'b0) begin
                    n_err++;
                    $display("FAIL random k=%0d t=%0d vld=%b dout=%h expected vld=%b dout=%h",
                             k, t, obs_vld(k), obs_dout(k), e_vld[k], e_dout[k]);
                end
            end
        end
        re = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset_mid();
        int done [NI];
        re = 1'b1; ra = 4'd3;
        tick();
        re = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < NI; k++) begin
            n_chk++;
            if (obs_dout(k) !== 128'h0 || obs_vld(k) !== 1'b0 || obs_busy(k) !== 1'b1) begin
                n_err++;
                $display("FAIL async_rst k=%0d dout=%h vld=%b busy=%b expected 0 0 1",
                         k, obs_dout(k), obs_vld(k), obs_busy(k));
            end
        end
        tick();
        rst = 1'b0;
        for (int t = 0; t < 8; t++) tick();
        #2 rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
        for (int k = 0; k < NI; k++) done[k] = -1;
        for (int t = 1; t <= 24; t++) begin
            tick();
            for (int k = 0; k < NI; k++) if (done[k] < 0 && obs_busy(k) === 1'b0) done[k] = t;
        end
        for (int k = 0; k < NI; k++) begin
            n_chk++;
            if (done[k] !== dep(k)) begin
                n_err++;
                $display("FAIL restart_len k=%0d busy_cycles=%0d expected %0d", k, done[k], dep(k));
            end
        end
        for (int t = 0; t < 18; t++) begin
            re = (t < 16); ra = 4'(t);
            tick();
            for (int k = 0; k < NI; k++) begin
                n_chk++;
                if (obs_vld(k) !== e_vld[k] || (e_vld[k] && obs_dout(k) !== 128'h0)) begin
                    n_err++;
                    $display("FAIL restart_zero k=%0d t=%0d vld=%b dout=%h expected vld=%b dout=0",
                             k, t, obs_vld(k), obs_dout(k), e_vld[k]);
                end
            end
        end
        re = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", n_chk, n_err);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_init_sweep();
        test_read_zero();
        test_mask_write();
        test_bypass();
        test_back_to_back();
        test_hold();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/sa_ram_rws_param.md
SA_RAM_RWS_PARAM -- requirements
Module: sa_ram_rws_param

Interface
REQ-001 Parameter DEPTH, default 16: number of words.
REQ-002 Parameter WIDTH, default 128: bits per word.
REQ-003 Parameter AW, default 4: address width; DEPTH SHALL satisfy DEPTH <= 2^AW.
REQ-004 Parameter MASK_W, default 16: write-enable lanes; WIDTH SHALL be a multiple of MASK_W, lane i = bits [(i+1)*WIDTH/MASK_W-1 : i*WIDTH/MASK_W].
REQ-005 Parameter BYPASS, default 1: 1 = read-during-write to the same address returns new data; 0 = returns old data.
REQ-006 Parameter OUT_REG, default 0: 1 = one extra output pipeline stage.
REQ-007 clk  input  1  sole clock; all state on rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 ra  input  AW  read address.
REQ-010 re  input  1  read enable.
REQ-011 wa  input  AW  write address.
REQ-012 we  input  1  write enable.
REQ-013 wmask  input  MASK_W  per-lane write enable; a lane is written only when we=1 and its bit is 1.
REQ-014 di  input  WIDTH  write data.
REQ-015 dout  output  WIDTH  read data.
REQ-016 dout_vld  output  1  one-cycle pulse marking new data on dout.
REQ-017 init_busy  output  1  high while the zero-initialisation sweep runs.
REQ-018 pwrbus_ram_pd  input  32  power-control bus; accepted and ignored.

Function
REQ-019 The FSM SHALL have two states: INIT and READY; reset forces INIT with the sweep counter at 0.
REQ-020 In INIT, each cycle SHALL write all-zero to M[cnt] and increment cnt; when cnt==DEPTH-1, the FSM SHALL go to READY on that edge (INIT lasts exactly DEPTH cycles).
REQ-021 init_busy SHALL be 1 in INIT and 0 in READY.
REQ-022 re and we SHALL be ignored while init_busy=1: no write, no dout change, no dout_vld.
REQ-023 In READY, a write SHALL update only the masked lanes of M[wa] at the clock edge; unmasked lanes keep their value.
REQ-024 In READY, re=1 in cycle N SHALL capture the word at ra into the read data register at edge N.
REQ-025 With OUT_REG=0, captured data SHALL appear on dout in cycle N+1 with dout_vld=1.
REQ-026 With OUT_REG=1, captured data SHALL appear on dout in cycle N+2 with dout_vld=1.
REQ-027 Back-to-back reads SHALL be accepted every cycle, at full throughput.
REQ-028 dout SHALL hold its last value when no read completes; dout_vld SHALL be 0 in that case.
REQ-029 Later writes to the address SHALL NOT alter dout; it is captured data, not a live array lookup.
REQ-030 If re and we are both 1 and ra==wa, BYPASS=1 SHALL return the masked merge of di over the old word, and BYPASS=0 SHALL return the old word.
REQ-031 With both enables active and ra!=wa, the read and the write SHALL proceed independently.
REQ-032 A write with wa >= DEPTH SHALL be dropped.
REQ-033 A read with ra >= DEPTH SHALL return all-zero, with dout_vld still asserted.
REQ-034 we=1 with wmask=0 SHALL leave memory unchanged, and bypass SHALL return the old word.

Reset
REQ-035 On rst=1, immediately: dout=0, dout_vld=0, init_busy=1, OUT_REG stage=0, state=INIT, cnt=0.
REQ-036 Asserting rst mid-INIT or mid-read SHALL abort the operation; the sweep SHALL restart from address 0 after release.
REQ-037 Memory contents are not reset directly; they are cleared only by the sweep.

Verification
REQ-038 Release reset -> init_busy=1 for exactly 16 cycles then 0; reading addresses 0..15 -> all return 0 with dout_vld pulses.
REQ-039 Write wa=3, di=all-ones, wmask=16'h00FF, then read ra=3 -> dout = 128'h0...0_FFFF_FFFF_FFFF_FFFF one cycle after re (OUT_REG=0).
REQ-040 Same cycle: re=1, we=1, ra=wa=5, old word 0, di=all-ones, wmask=all -> BYPASS=1 gives all-ones; BYPASS=0 gives 0, and the next read gives all-ones.
REQ-041 With OUT_REG=1, reads on 4 consecutive cycles of addresses 0..3 -> 4 consecutive dout_vld pulses starting 2 cycles after the first re, data in order.
REQ-042 re/we asserted during INIT -> no dout_vld, and memory is still 0 after the sweep; asserting rst at sweep cycle 8 -> init_busy stays high for 16 cycles after release.
REQ-043 Read at address 7 captures value A; a write of B to address 7 in the next cycle -> dout stays A until the next re.
